// File: rtl/test_pe_out_fifo.sv
// test_pe_out_fifo: capture stage behind the PE.
// The stage takes {res_p, res} on every clk_en cycle while capture is enabled.
// It buffers the entries in a show-ahead FIFO and presents them on a
// valid/ready handshake.
// The control/status register at CfgAddr holds three bits:
//   bit0 capture_en
//   bit1 drop_mode (0 = drop newest, 1 = overwrite oldest)
//   bit2 flush (self-clearing)
// Optional feature macro: TEST_PE_OUT_FIFO_HWM_EN (high-water-mark register
// at read_data[23:16]).
module test_pe_out_fifo #(
  parameter int         DataWidth = 16,
  parameter int         Depth     = 4,
  parameter logic [7:0] CfgAddr   = 8'hE8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic [DataWidth-1:0]   res,
  input  logic                   res_p,
  input  logic [31:0]            cfg_d,
  input  logic [7:0]             cfg_a,
  input  logic                   cfg_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DataWidth-1:0]   out_data,
  output logic                   out_p,
  output logic [$clog2(Depth):0] count,
  output logic                   ovfl,
  output logic [31:0]            read_data
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam int EW = DataWidth + 1;
  localparam logic [CW-1:0] FullCount = CW'(Depth);

  logic [EW-1:0] r_mem [Depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovfl;
  logic          r_capture_en;
  logic          r_drop_mode;

  logic          w_cfg_hit;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_wr_en;
  logic          w_rd_adv;
  logic          w_ovfl_set;
  logic [CW-1:0] w_count_nxt;
  logic [EW-1:0] w_head;
  logic [7:0]    w_hwm_field;

  // Push uses the control value held before any same-cycle cfg write.
  assign w_cfg_hit = cfg_en && (cfg_a == CfgAddr);
  assign w_flush   = w_cfg_hit && cfg_d[2];
  assign w_push    = clk_en && r_capture_en;
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_count == FullCount);

  // Decide which pointers move, the next occupancy, and whether an overflow occurred.
  always_comb begin
    w_wr_en     = 1'b0;
    w_rd_adv    = 1'b0;
    w_ovfl_set  = 1'b0;
    w_count_nxt = r_count;
    if (w_push) begin
      if (!w_full || w_pop) begin
        w_wr_en = 1'b1;
      end else if (r_drop_mode) begin
        // Full and overwriting: evict the oldest entry to make room.
        w_wr_en    = 1'b1;
        w_rd_adv   = 1'b1;
        w_ovfl_set = 1'b1;
      end else begin
        // Full and dropping: the new entry is discarded.
        w_ovfl_set = 1'b1;
      end
    end else begin
      w_wr_en = 1'b0;
    end
    if (w_pop) begin
      w_rd_adv = 1'b1;
    end else begin
      w_rd_adv = w_rd_adv;
    end
    if (w_wr_en && !w_rd_adv) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_en && w_rd_adv) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointers, occupancy and sticky overflow. Flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ovfl   <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ovfl   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      if (w_ovfl_set) begin
        r_ovfl <= 1'b1;
      end
    end
  end

  // Entry storage. Nothing is written in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= {EW{1'b0}};
      end
    end else if (w_wr_en && !w_flush) begin
      r_mem[r_wr_ptr] <= {res_p, res};
    end
  end

  // Control bits load from cfg_d on a write to CfgAddr. The flush bit is not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capture_en <= 1'b0;
      r_drop_mode  <= 1'b0;
    end else if (w_cfg_hit) begin
      r_capture_en <= cfg_d[0];
      r_drop_mode  <= cfg_d[1];
    end
  end

`ifdef TEST_PE_OUT_FIFO_HWM_EN
  logic [7:0] r_hwm;
  logic [7:0] w_count_nxt8;

  assign w_count_nxt8 = 8'(w_count_nxt);

  // Track the peak occupancy, updated on the same edge as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= 8'h00;
    end else if (w_flush) begin
      r_hwm <= 8'h00;
    end else if (w_count_nxt8 > r_hwm) begin
      r_hwm <= w_count_nxt8;
    end
  end

  assign w_hwm_field = r_hwm;
`else
  assign w_hwm_field = 8'h00;
`endif

  // Show-ahead head. The outputs read zero while the FIFO is empty.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != {CW{1'b0}});
  assign out_data  = out_valid ? w_head[DataWidth-1:0] : {DataWidth{1'b0}};
  assign out_p     = out_valid ? w_head[DataWidth] : 1'b0;
  assign count     = r_count;
  assign ovfl      = r_ovfl;

  // Combinational readback. It is OR-combined upstream, so it is zero off-address.
  assign read_data = (cfg_a == CfgAddr) ?
                     {8'h00, w_hwm_field, 8'(r_count), 4'h0, r_ovfl, 1'b0, r_drop_mode, r_capture_en} :
                     32'h0000_0000;

endmodule

// File: tb/tb_test_pe_out_fifo.sv
// Directed, scoreboard-checked bench for test_pe_out_fifo.
// A queue model predicts the contents, the head, the count, the overflow flag,
// the high-water mark and the readback word.
module tb_test_pe_out_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic [DW-1:0] res;
  logic          res_p;
  logic [31:0]   cfg_d;
  logic [7:0]    cfg_a;
  logic          cfg_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_p;
  logic [2:0]    count;
  logic          ovfl;
  logic [31:0]   read_data;

  int total = 0;
  int bad = 0;

  // Model state.
  logic [DW:0] q[$];
  logic        m_cap;
  logic        m_drop;
  logic        m_ovfl;
  int          m_hwm;

  test_pe_out_fifo #(.DataWidth(DW), .Depth(DEPTH), .CfgAddr(8'hE8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .res(res), .res_p(res_p),
    .cfg_d(cfg_d), .cfg_a(cfg_a), .cfg_en(cfg_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_p(out_p), .count(count), .ovfl(ovfl), .read_data(read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cap = 1'b0;
    m_drop = 1'b0;
    m_ovfl = 1'b0;
    m_hwm = 0;
  endtask

  function automatic logic [31:0] exp_rd();
    logic [7:0] hwm8;
`ifdef TEST_PE_OUT_FIFO_HWM_EN
    hwm8 = 8'(m_hwm);
`else
    hwm8 = 8'h00;
`endif
    if (cfg_a == 8'hE8) begin
      exp_rd = {8'h00, hwm8, 8'(q.size()), 4'h0, m_ovfl, 1'b0, m_drop, m_cap};
    end else begin
      exp_rd = 32'h0;
    end
  endfunction

  // Compare every observable output against the model.
  task automatic check_state(input string where);
    chk({where, ".count"}, 32'(count), 32'(q.size()));
    chk({where, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({where, ".ovfl"}, 32'(ovfl), 32'(m_ovfl));
    if (q.size() != 0) begin
      chk({where, ".head"}, 32'({out_p, out_data}), 32'(q[0]));
    end else begin
      chk({where, ".empty_out"}, 32'({out_p, out_data}), 32'h0);
    end
    chk({where, ".read_data"}, read_data, exp_rd());
  endtask

  // One clock: drive the inputs mid-cycle, check, advance the model, then take the edge.
  task automatic cyc(input string where, input logic ce, input logic [DW-1:0] d, input logic p,
                     input logic rdy, input logic cen, input logic [31:0] cd);
    logic        do_push;
    logic        do_pop;
    logic [DW:0] popped;
    @(negedge clk);
    clk_en = ce; res = d; res_p = p; out_ready = rdy; cfg_en = cen; cfg_d = cd;
    #1;
    check_state(where);
    do_push = ce && m_cap;
    do_pop = (q.size() != 0) && rdy;
    if (cen && cfg_a == 8'hE8 && cd[2]) begin
      q.delete();
      m_ovfl = 1'b0;
      m_hwm = 0;
    end else begin
      if (do_pop) begin
        popped = q.pop_front();
        chk({where, ".pop"}, 32'({out_p, out_data}), 32'(popped));
      end
      if (do_push) begin
        if (q.size() < DEPTH) begin
          q.push_back({p, d});
        end else if (m_drop) begin
          void'(q.pop_front());
          q.push_back({p, d});
          m_ovfl = 1'b1;
        end else begin
          m_ovfl = 1'b1;
        end
      end
      if (q.size() > m_hwm) m_hwm = q.size();
    end
    if (cen && cfg_a == 8'hE8) begin
      m_cap = cd[0];
      m_drop = cd[1];
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; res = 16'h0; res_p = 1'b0;
    cfg_d = 32'h0; cfg_a = 8'hE8; cfg_en = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Enable capture and fill the FIFO with out_ready low.
    cyc("cfg_cap", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc("fill", 1'b1, 16'h0011 + 16'(i), 1'b0, 1'b0, 1'b0, 32'h0);
    end
    // Full with drop newest: 0015 is lost and ovfl sets.
    cyc("full_drop", 1'b1, 16'h0015, 1'b0, 1'b0, 1'b0, 32'h0);
    // Switch to overwrite-oldest, then push 0016 so the head becomes 0012.
    cyc("cfg_ovw", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'h3);
    cyc("full_ovw", 1'b1, 16'h0016, 1'b0, 1'b0, 1'b0, 32'h0);
    // Push and pop together while full.
    cyc("full_pushpop", 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 32'h0);
    // Drain all entries, which checks the tail is AAAA.
    for (int i = 0; i < 4; i++) begin
      cyc("drain", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    // Single push into an empty FIFO: valid appears only after the edge.
    cyc("empty_push", 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0, 32'h0);
    // clk_en low holds the count for three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc("ce_low", 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    // Flush with a push in the same cycle.
    cyc("flush", 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 32'h4);
    cyc("post_flush", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // High-water mark: fill to 3, then drain to 0.
    cyc("cfg_cap2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc("hwm_fill", 1'b1, 16'h0100 + 16'(i), 1'(i), 1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc("hwm_drain", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
`ifdef TEST_PE_OUT_FIFO_HWM_EN
    chk("hwm_field", 32'(read_data[23:16]), 32'h03);
`else
    chk("hwm_field", 32'(read_data[23:16]), 32'h00);
`endif
    chk("hwm_count_field", 32'(read_data[15:8]), 32'h00);
    cfg_a = 8'h00;
    #1;
    chk("rd_offaddr", read_data, 32'h0);
    cfg_a = 8'hE8;

    // Reset asserted in the middle of operation clears all state at once.
    cyc("pre_rst", 1'b1, 16'h0777, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("pre_rst", 1'b1, 16'h0778, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clk_en = 1'b0;
    #1;
    chk("pre_rst.count", 32'(count), 32'h2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("after_rst", 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("after_rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
